// File: rtl/router_2_input_port.sv
// ---------------------------------------------------------------------------
// router_2_input_port
//   Input port of router 2 in a 2x2 mesh. Incoming flits are buffered in a
//   small FIFO. The HEADER flit at the FIFO head is XY-routed, and the chosen
//   output is then held until the packet's TAIL flit has been popped.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   in_flit, in_valid        flit from the upstream link
//   in_ready                 !full; a write happens iff in_valid & in_ready
//   out_flit                 FIFO head flit (0 when empty)
//   out_flit_type            head[31:29] (0 when empty)
//   out_length               head[28:17] (0 when empty)
//   Lreq, Nreq, Ereq         request to the Local/North/East output arbiter
//   Lgrant, Ngrant, Egrant   this port currently owns that output
//   drop_err                 pulse while a non-HEADER flit is discarded in IDLE
//   occupancy                number of stored flits, 0..DEPTH
// ---------------------------------------------------------------------------
module router_2_input_port #(
    parameter int         DATA_WIDTH = 32,
    parameter int         DEPTH      = 4,
    parameter int         ADDR_W     = 2,
    parameter int         MY_X       = 0,
    parameter int         MY_Y       = 1,
    parameter logic [2:0] HDR_CODE   = 3'b001,
    parameter logic [2:0] TAIL_CODE  = 3'b100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_flit,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_flit,
    output logic [2:0]            out_flit_type,
    output logic [11:0]           out_length,
    output logic                  Lreq,
    output logic                  Nreq,
    output logic                  Ereq,
    input  logic                  Lgrant,
    input  logic                  Ngrant,
    input  logic                  Egrant,
    output logic                  drop_err,
    output logic [ADDR_W:0]       occupancy
);

    localparam logic              MY_X_BIT   = 1'(MY_X);
    localparam logic              MY_Y_BIT   = 1'(MY_Y);
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);

    // Route vectors are one-hot {L, N, E}
    localparam logic [2:0] ROUTE_L = 3'b100;
    localparam logic [2:0] ROUTE_N = 3'b010;
    localparam logic [2:0] ROUTE_E = 3'b001;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_ROUTED
    } state_t;

    // ------------------------------------------------------------------
    // Storage and pointers
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_reg;
    logic [ADDR_W-1:0]     rd_ptr_reg;
    logic [ADDR_W:0]       count_reg;

    state_t                state_reg;
    state_t                state_next;
    logic [2:0]            route_reg;
    logic [2:0]            route_next;

    logic                  empty;
    logic                  full;
    logic                  wr_en;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;
    logic [2:0]            head_type;
    logic [2:0]            route_calc;
    logic [2:0]            grant_vec;
    logic [2:0]            req_vec;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == FULL_COUNT);
    assign in_ready  = ~full;
    assign wr_en     = in_valid & ~full;
    assign occupancy = count_reg;

    // Head is read straight from the array; a freshly written entry only
    // becomes the head once count_reg has counted it, i.e. the next cycle.
    assign head      = mem[rd_ptr_reg];
    assign head_type = head[DATA_WIDTH-1 -: 3];

    assign out_flit      = empty ? '0 : head;
    assign out_flit_type = empty ? 3'b000 : head_type;
    assign out_length    = empty ? 12'd0 : head[DATA_WIDTH-4 -: 12];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= in_flit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // XY routing of the head flit: resolve X first, then Y, else local
    // ------------------------------------------------------------------
    always_comb begin
        route_calc = ROUTE_L;
        if (head[1] != MY_X_BIT) begin
            route_calc = ROUTE_E;
        end else if (head[0] != MY_Y_BIT) begin
            route_calc = ROUTE_N;
        end
    end

    assign grant_vec = {Lgrant, Ngrant, Egrant};

    // ------------------------------------------------------------------
    // Packet FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            route_reg <= '0;
        end else begin
            state_reg <= state_next;
            route_reg <= route_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        route_next = route_reg;
        pop        = 1'b0;
        drop_err   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!empty) begin
                    if (head_type == HDR_CODE) begin
                        state_next = ST_ROUTED;
                        route_next = route_calc;
                    end else begin
                        // Stray flit outside a packet: discard it
                        pop      = 1'b1;
                        drop_err = 1'b1;
                    end
                end
            end
            ST_ROUTED: begin
                // Only the grant of the held route can pop; others are ignored
                if (!empty && ((grant_vec & route_reg) != 3'b000)) begin
                    pop = 1'b1;
                    if (head_type == TAIL_CODE) begin
                        state_next = ST_IDLE;
                        route_next = '0;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                route_next = '0;
            end
        endcase
    end

    // Requests follow the held route while there is something to send
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_req
            assign req_vec[gi] = (state_reg == ST_ROUTED) & route_reg[gi] & ~empty;
        end
    endgenerate

    assign {Lreq, Nreq, Ereq} = req_vec;

endmodule

// File: tb/tb_router_2_input_port.sv
module tb_router_2_input_port;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_flit;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_flit;
    logic [2:0]  out_flit_type;
    logic [11:0] out_length;
    logic        Lreq, Nreq, Ereq;
    logic [2:0]  gnt;            // bit 0 = L, 1 = N, 2 = E
    logic        drop_err;
    logic [2:0]  occupancy;

    always #5 clk = ~clk;

    router_2_input_port dut (
        .clk           (clk),
        .rst           (rst),
        .in_flit       (in_flit),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_flit      (out_flit),
        .out_flit_type (out_flit_type),
        .out_length    (out_length),
        .Lreq          (Lreq),
        .Nreq          (Nreq),
        .Ereq          (Ereq),
        .Lgrant        (gnt[0]),
        .Ngrant        (gnt[1]),
        .Egrant        (gnt[2]),
        .drop_err      (drop_err),
        .occupancy     (occupancy)
    );

    // ------------------------------------------------------------------
    // Reference model: stream-level packet interpretation.
    // kind 0 = discarded stray, 1 = header, 2 = body/tail of a packet.
    // port 0 = L, 1 = N, 2 = E.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] flit;
        logic [1:0]  kind;
        logic [1:0]  port;
    } ent_t;

    ent_t        exp_q[$];
    logic [31:0] tx_q[$];
    bit          m_in_pkt;
    int          m_port;

    int n_vec = 0;
    int n_err = 0;

    logic [2:0] body_codes [5] = '{3'b010, 3'b000, 3'b111, 3'b011, 3'b001};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Router 2 sits at (0,1): X mismatch -> East, else Y mismatch -> North
    function automatic int route_of(input logic [31:0] f);
        if (f[1] != 1'b0) return 2;
        if (f[0] != 1'b1) return 1;
        return 0;
    endfunction

    task automatic model_accept(input logic [31:0] f);
        ent_t e;
        e.flit = f;
        if (!m_in_pkt) begin
            if (f[31:29] == 3'b001) begin
                e.kind   = 2'd1;
                m_port   = route_of(f);
                e.port   = 2'(m_port);
                m_in_pkt = 1'b1;
            end else begin
                e.kind = 2'd0;
                e.port = 2'd0;
            end
        end else begin
            e.kind = 2'd2;
            e.port = 2'(m_port);
            if (f[31:29] == 3'b100) m_in_pkt = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    task automatic gen_packet(input int len, input bit dx, input bit dy);
        logic [31:0] f;
        f = {3'b001, 12'(len), 15'($urandom), dx, dy};
        tx_q.push_back(f);
        for (int i = 1; i < len - 1; i++) begin
            f = $urandom;
            f[31:29] = body_codes[$urandom_range(0, 4)];
            tx_q.push_back(f);
        end
        f = $urandom;
        f[31:29] = 3'b100;
        tx_q.push_back(f);
    endtask

    task automatic gen_stray();
        logic [31:0] f;
        f = $urandom;
        f[31:29] = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'b100;
        tx_q.push_back(f);
    endtask

    // ------------------------------------------------------------------
    // Driver: one clock per call. Entered and left at posedge + 1.
    // gmode: 0 random grants, 1 no grants, 2 all grants.
    // ------------------------------------------------------------------
    task automatic step(input int vprob, input int gmode, input bit gen);
        bit acc;
        if (gen && tx_q.size() < 8) begin
            if ($urandom_range(0, 9) == 0) gen_stray();
            else gen_packet($urandom_range(2, 5), 1'($urandom), 1'($urandom));
        end
        in_valid = (tx_q.size() > 0) && ($urandom_range(0, 99) < vprob);
        in_flit  = in_valid ? tx_q[0] : 32'h0;
        case (gmode)
            0:       gnt = 3'($urandom);
            1:       gnt = 3'b000;
            default: gnt = 3'b111;
        endcase
        @(negedge clk);
        acc = in_valid && in_ready && !rst;
        @(posedge clk);
        #1;
        if (acc) model_accept(tx_q.pop_front());
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_in_pkt = 1'b0;
        // Outputs must already reflect the empty, idle port
        chk("rst_in_ready",  32'(in_ready), 32'd1);
        chk("rst_req",       32'({Lreq, Nreq, Ereq}), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_flit_type", 32'(out_flit_type), 32'd0);
        chk("rst_out_flit",  out_flit, 32'd0);
        chk("rst_drop_err",  32'(drop_err), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Monitor: checks outputs mid-cycle, pops the scoreboard when the
    // model says a flit leaves at the coming edge.
    // ------------------------------------------------------------------
    int          head_age = 0;
    int          qs;
    ent_t        h;
    logic [2:0]  exp_req;
    logic [2:0]  obs_req;
    bit          exp_drop;
    bit          exp_pop;
    bit          obs_pop;

    always @(negedge clk) begin
        if (!rst) begin
            qs       = exp_q.size();
            exp_req  = 3'b000;
            exp_drop = 1'b0;
            exp_pop  = 1'b0;
            obs_req  = {Ereq, Nreq, Lreq};
            chk("occupancy", 32'(occupancy), 32'(qs));
            chk("in_ready",  32'(in_ready), (qs < DEPTH) ? 32'd1 : 32'd0);
            if (qs == 0) begin
                chk("empty_flit",   out_flit, 32'd0);
                chk("empty_type",   32'(out_flit_type), 32'd0);
                chk("empty_length", 32'(out_length), 32'd0);
            end else begin
                h = exp_q[0];
                chk("out_flit",   out_flit, h.flit);
                chk("flit_type",  32'(out_flit_type), 32'(h.flit[31:29]));
                chk("out_length", 32'(out_length), 32'(h.flit[28:17]));
                if (h.kind == 2'd0) begin
                    exp_drop = 1'b1;
                    exp_pop  = 1'b1;
                end else begin
                    // A header is routed during its first cycle at the head
                    if (h.kind == 2'd2 || head_age >= 1) exp_req[h.port] = 1'b1;
                    exp_pop = (exp_req & gnt) != 3'b000;
                end
            end
            chk("req",      32'(obs_req), 32'(exp_req));
            chk("drop_err", 32'(drop_err), 32'(exp_drop));
            obs_pop = drop_err || ((obs_req & gnt) != 3'b000);
            chk("pop", 32'(obs_pop), 32'(exp_pop));
            if (exp_pop) begin
                h = exp_q.pop_front();
                if (h.kind == 2'd0)
                    $display("[%0t] drop    flit=%08h", $time, h.flit);
                else
                    $display("[%0t] deliver flit=%08h port=%s", $time, h.flit,
                             (h.port == 2'd0) ? "L" : (h.port == 2'd1) ? "N" : "E");
                head_age = 0;
            end else if (qs == 0) begin
                head_age = 0;
            end else begin
                head_age++;
            end
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_flit  = 32'h0;
        gnt      = 3'b000;
        m_in_pkt = 1'b0;
        m_port   = 0;
        do_reset(2);

        // Directed traffic: local, east, stray, north, back-to-back packets
        gen_packet(3, 1'b0, 1'b1);
        gen_packet(2, 1'b1, 1'b0);
        gen_stray();
        gen_packet(4, 1'b0, 1'b0);
        gen_packet(2, 1'b0, 1'b0);
        gen_packet(2, 1'b1, 1'b1);
        repeat (60)  step(80, 0, 1'b0);
        repeat (20)  step(100, 2, 1'b0);

        // Back-pressure: fill the FIFO with no grants, then release
        repeat (30)  step(100, 1, 1'b1);
        repeat (150) step(70, 0, 1'b1);

        // Reset in the middle of traffic
        repeat (3)   step(100, 1, 1'b1);
        do_reset(1);
        repeat (250) step(70, 0, 1'b1);
        repeat (20)  step(100, 1, 1'b1);
        do_reset(2);
        repeat (150) step(60, 0, 1'b1);

        // Drain everything still queued
        repeat (150) step(100, 2, 1'b0);
        chk("drain_tx",  32'(tx_q.size()), 32'd0);
        chk("drain_exp", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
